uart_sync_fifo: RTL

Single-clock FIFO that buffers byte traffic between the APB register map and the UART serial engines. Two instances are used:
- Downstream (DFIFO): the register map writes TX bytes into it; the transmitter drains it.
- Upstream (UFIFO): the receiver fills it; the register map pops it on a read of the UFIFO register.
The FIFO is first-word-fall-through, supplies the full/empty/used status that the register map exposes, and has an optional per-entry parity check.

---
 rtl/uart_sync_fifo.sv | 114 +++++++++++
 1 files changed

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through byte FIFO between the APB register map and the UART engines.
// Optional per-entry even-parity bit catches storage corruption when an entry is popped.
module uart_sync_fifo #(
   parameter int DATA_WIDTH      = 8,
   parameter int DEPTH           = 16,
   parameter int DEPTH_WIDTH     = $clog2(DEPTH) + 1,
   parameter bit PARITY_CHECK_EN = 1'b1
) (
   input  logic                   i_apb_pclk,
   input  logic                   i_apb_presetn,
   input  logic                   i_flush,
   input  logic                   i_wr_req,
   input  logic [DATA_WIDTH-1:0]  i_wr_data,
   input  logic                   i_parity_inject,
   input  logic                   i_rd_req,
   output logic [DATA_WIDTH-1:0]  o_rd_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [DEPTH_WIDTH-1:0] o_used,
   output logic                   o_overflow,
   output logic                   o_underflow,
   output logic                   o_parity_err
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   logic [AW:0]            wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [DEPTH_WIDTH-1:0] used_q, used_nxt;
   logic                   full_q, empty_q;
   logic                   push_acc, pop_acc, pop_bad;
   logic                   overflow_p1, underflow_p1, parity_err_p1;
   logic [DATA_WIDTH-1:0]  head_data;

   function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
      return ^d;
   endfunction

   assign head_data = mem[rd_ptr[AW-1:0]];

   // At full, a push only gets in alongside a pop, which is always valid there.
   assign push_acc = i_apb_presetn && !i_flush && i_wr_req && (!full_q || i_rd_req);
   assign pop_acc  = i_apb_presetn && !i_flush && i_rd_req && !empty_q;

   always_comb begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      used_nxt   = used_q;
      if (push_acc)
         wr_ptr_nxt = wr_ptr + (AW+1)'(1);
      if (pop_acc)
         rd_ptr_nxt = rd_ptr + (AW+1)'(1);
      if (push_acc && !pop_acc)
         used_nxt = used_q + DEPTH_WIDTH'(1);
      else if (!push_acc && pop_acc)
         used_nxt = used_q - DEPTH_WIDTH'(1);
   end

   // Stage p1: pointers, occupancy flags and status pulses
   always_ff @(posedge i_apb_pclk) begin
      if (!i_apb_presetn || i_flush) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         used_q        <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         overflow_p1   <= 1'b0;
         underflow_p1  <= 1'b0;
         parity_err_p1 <= 1'b0;
      end else begin
         wr_ptr        <= wr_ptr_nxt;
         rd_ptr        <= rd_ptr_nxt;
         used_q        <= used_nxt;
         full_q        <= (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]) &&
                          (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]);
         empty_q       <= (wr_ptr_nxt == rd_ptr_nxt);
         overflow_p1   <= i_wr_req && !push_acc;
         underflow_p1  <= i_rd_req && empty_q;
         parity_err_p1 <= pop_acc && pop_bad;
      end
   end

   // Storage is never cleared; pointers alone define the contents.
   always_ff @(posedge i_apb_pclk) begin
      if (push_acc)
         mem[wr_ptr[AW-1:0]] <= i_wr_data;
   end

   generate
      if (PARITY_CHECK_EN) begin : g_par
         logic par_mem [DEPTH];

         always_ff @(posedge i_apb_pclk) begin
            if (push_acc)
               par_mem[wr_ptr[AW-1:0]] <= even_parity(i_wr_data) ^ i_parity_inject;
         end

         assign pop_bad = (even_parity(head_data) != par_mem[rd_ptr[AW-1:0]]);
      end else begin : g_nopar
         logic unused_inject;
         assign unused_inject = i_parity_inject;
         assign pop_bad       = 1'b0;
      end
   endgenerate

   assign o_rd_data    = empty_q ? '0 : head_data;
   assign o_full       = full_q;
   assign o_empty      = empty_q;
   assign o_used       = used_q;
   assign o_overflow   = overflow_p1;
   assign o_underflow  = underflow_p1;
   assign o_parity_err = parity_err_p1;

endmodule
